memory_access: RTL and testbench

//  MIPS pipeline stage 4: consumes EX/MEM register outputs of execute stage, resolves branches,

---
 rtl/memory_access.sv | 138 +++++++++++++
 tb/tb_memory_access.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MIPS memory-access stage: branch resolution, byte/half/word data memory
// accesses and the MEM/WB pipeline register, plus a word-wide debug read port.
module memory_access #(
    parameter int len         = 32,
    parameter int NB          = 5,
    parameter int len_mem_bus = 9,
    parameter int len_wb_bus  = 2,
    parameter int depth       = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [len-1:0]           in_alu,
    input  logic [len-1:0]           in_reg2,
    input  logic [NB-1:0]            in_write_reg,
    input  logic [len-1:0]           in_pc_branch,
    input  logic                     zero_flag,
    input  logic [len_mem_bus-1:0]   memory_bus,
    input  logic [len_wb_bus-1:0]    writeBack_bus,
    input  logic                     halt_flag_m,
    input  logic [$clog2(depth)-1:0] debug_addr,
    output logic                     pc_src,
    output logic [len-1:0]           out_pc_branch,
    output logic [len-1:0]           out_read_data,
    output logic [len-1:0]           out_alu,
    output logic [NB-1:0]            out_write_reg,
    output logic [len_wb_bus-1:0]    writeBack_bus_out,
    output logic                     out_misaligned,
    output logic                     out_halt_flag_m,
    output logic [len-1:0]           debug_data
);

    localparam int AW = $clog2(depth);

    // Pick the addressed lane out of a word and extend it to the full width.
    function automatic logic [len-1:0] load_extract(
        input logic [len-1:0] word,
        input logic [1:0]     lane,
        input logic [1:0]     size,
        input logic           uns
    );
        logic signed [7:0]  v_b;
        logic signed [15:0] v_h;
        logic [len-1:0]     v_res;
        v_b = word[8*lane +: 8];
        v_h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   v_res = uns ? {{(len-8){1'b0}}, v_b}  : {{(len-8){v_b[7]}}, v_b};
            2'b01:   v_res = uns ? {{(len-16){1'b0}}, v_h} : {{(len-16){v_h[15]}}, v_h};
            default: v_res = word;  // 11 and the reserved 10 both mean word
        endcase
        return v_res;
    endfunction

    logic [len-1:0] r_mem [0:depth-1];

    logic            w_wr;
    logic            w_rd;
    logic            w_uns;
    logic [1:0]      w_size;
    logic [1:0]      w_lane;
    logic [AW-1:0]   w_word_idx;
    logic            w_misaligned_raw;
    logic            w_misaligned_op;
    logic [3:0]      w_be;
    logic [len-1:0]  w_wdata;
    logic [len-1:0]  w_rd_word;
    logic [len-1:0]  w_load;
    logic            w_unused;

    assign w_wr       = memory_bus[8];
    assign w_rd       = memory_bus[7];
    assign w_uns      = memory_bus[6];
    assign w_size     = memory_bus[5:4];
    assign w_lane     = in_alu[1:0];
    assign w_word_idx = in_alu[AW+1:2];   // upper address bits wrap modulo depth

    // Reserved control bits and address bits above the memory are ignored.
    assign w_unused = ^{in_alu[len-1:AW+2], memory_bus[1:0]};

    assign pc_src        = (memory_bus[3] & zero_flag) | (memory_bus[2] & ~zero_flag);
    assign out_pc_branch = in_pc_branch;
    assign debug_data    = r_mem[debug_addr];

    // Alignment check, store lane enables and load data path.
    always_comb begin
        w_misaligned_raw = 1'b0;
        w_be             = 4'b0000;
        w_wdata          = in_reg2;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{in_reg2[7:0]}};
            end
            2'b01: begin
                w_misaligned_raw = w_lane[0];
                w_be             = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata          = {2{in_reg2[15:0]}};
            end
            default: begin
                w_misaligned_raw = |w_lane;
                w_be             = 4'b1111;
            end
        endcase
        w_misaligned_op = (w_wr | w_rd) & w_misaligned_raw;
        w_rd_word       = r_mem[w_word_idx];
        w_load          = (w_rd & ~w_misaligned_raw)
                        ? load_extract(w_rd_word, w_lane, w_size, w_uns) : '0;
    end

    // Data memory write: byte-lane enables, suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && w_wr && !w_misaligned_raw) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_read_data     <= '0;
            out_alu           <= '0;
            out_write_reg     <= '0;
            writeBack_bus_out <= '0;
            out_misaligned    <= 1'b0;
            out_halt_flag_m   <= 1'b0;
        end else begin
            out_read_data     <= w_load;
            out_alu           <= in_alu;
            out_write_reg     <= in_write_reg;
            writeBack_bus_out <= writeBack_bus;
            out_misaligned    <= w_misaligned_op;
            out_halt_flag_m   <= halt_flag_m;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access against a byte-addressed memory model.
module tb_memory_access;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   in_alu, in_reg2, in_pc_branch;
    logic [4:0]    in_write_reg;
    logic          zero_flag;
    logic [8:0]    memory_bus;
    logic [1:0]    writeBack_bus;
    logic          halt_flag_m;
    logic [AW-1:0] debug_addr;
    logic          pc_src;
    logic [31:0]   out_pc_branch, out_read_data, out_alu, debug_data;
    logic [4:0]    out_write_reg;
    logic [1:0]    writeBack_bus_out;
    logic          out_misaligned, out_halt_flag_m;

    always #5 clk = ~clk;

    memory_access #(.len(32), .NB(5), .len_mem_bus(9), .len_wb_bus(2), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_alu(in_alu), .in_reg2(in_reg2),
        .in_write_reg(in_write_reg), .in_pc_branch(in_pc_branch), .zero_flag(zero_flag),
        .memory_bus(memory_bus), .writeBack_bus(writeBack_bus), .halt_flag_m(halt_flag_m),
        .debug_addr(debug_addr), .pc_src(pc_src), .out_pc_branch(out_pc_branch),
        .out_read_data(out_read_data), .out_alu(out_alu), .out_write_reg(out_write_reg),
        .writeBack_bus_out(writeBack_bus_out), .out_misaligned(out_misaligned),
        .out_halt_flag_m(out_halt_flag_m), .debug_data(debug_data)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic        mis;
        logic        halt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         ntests = 0;
    int         nfail  = 0;
    bit         mem_known = 1'b0;
    logic [7:0] mb [DEPTH*4];

    function automatic logic [31:0] mword(int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one MEM/WB result per issued cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("out_read_data", out_read_data, mon_e.rd);
            chk("out_alu", out_alu, mon_e.alu);
            chk("out_write_reg", 32'(out_write_reg), 32'(mon_e.wreg));
            chk("writeBack_bus_out", 32'(writeBack_bus_out), 32'(mon_e.wb));
            chk("out_misaligned", 32'(out_misaligned), 32'(mon_e.mis));
            chk("out_halt_flag_m", 32'(out_halt_flag_m), 32'(mon_e.halt));
        end
    end

    // Issue one cycle of stimulus, check combinational outputs, predict the
    // registered result and update the memory model.
    task automatic cyc(input logic rst_n, input logic [8:0] bus, input logic [31:0] alu,
                       input logic [31:0] d, input logic zf, input logic [AW-1:0] dbg);
        exp_t        e;
        int          nbytes;
        int          a;
        logic        mis;
        logic        take;
        logic [31:0] v;
        @(negedge clk);
        reset         = rst_n;
        memory_bus    = bus;
        in_alu        = alu;
        in_reg2       = d;
        zero_flag     = zf;
        debug_addr    = dbg;
        in_write_reg  = 5'($urandom);
        in_pc_branch  = $urandom;
        writeBack_bus = 2'($urandom_range(0, 3));
        halt_flag_m   = 1'($urandom_range(0, 1));
        #1;
        if (mem_known) chk("debug_data", debug_data, mword(int'(dbg)));
        take = (bus[3] && zf) || (bus[2] && !zf);
        chk("pc_src", 32'(pc_src), 32'(take));
        chk("out_pc_branch", out_pc_branch, in_pc_branch);

        nbytes = (bus[5:4] == 2'b00) ? 1 : (bus[5:4] == 2'b01) ? 2 : 4;
        a      = int'(alu % 32'(DEPTH*4));
        mis    = (bus[8] || bus[7]) && ((a % nbytes) != 0);
        v      = 32'd0;
        if (bus[7] && !mis) begin
            for (int k = 0; k < nbytes; k++) v = v | (32'(mb[a+k]) << (8*k));
            if (!bus[6] && nbytes < 4 && v[8*nbytes-1])
                v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
        end
        if (rst_n) begin
            e.rd = v; e.alu = alu; e.wreg = in_write_reg; e.wb = writeBack_bus;
            e.mis = mis; e.halt = halt_flag_m;
        end else begin
            e.rd = '0; e.alu = '0; e.wreg = '0; e.wb = '0; e.mis = 1'b0; e.halt = 1'b0;
        end
        sb.push_back(e);
        if (rst_n && bus[8] && !mis)
            for (int k = 0; k < nbytes; k++) mb[a+k] = 8'(d >> (8*k));
    endtask

    initial begin
        int guard;
        reset = 1'b0; memory_bus = '0; in_alu = '0; in_reg2 = '0; zero_flag = 1'b0;
        debug_addr = '0; in_write_reg = '0; in_pc_branch = '0; writeBack_bus = '0;
        halt_flag_m = 1'b0;

        cyc(1'b0, 9'h000, 32'h0, 32'h0, 1'b0, 8'd0);
        cyc(1'b0, 9'h000, 32'h0, 32'h0, 1'b0, 8'd0);

        // Fill the whole memory so the model knows every word.
        for (int w = 0; w < DEPTH; w++) cyc(1'b1, 9'h130, 32'(w*4), $urandom, 1'b0, 8'd0);
        mem_known = 1'b1;

        // Store attempted during reset must leave memory alone.
        cyc(1'b0, 9'h100, 32'h40, 32'h000000A5, 1'b0, 8'h10);
        cyc(1'b1, 9'h000, 32'h0, 32'h0, 1'b0, 8'h10);

        // Word store then load.
        cyc(1'b1, 9'h130, 32'h10, 32'hDEADBEEF, 1'b0, 8'd4);
        cyc(1'b1, 9'h0B0, 32'h10, 32'h0, 1'b0, 8'd4);
        chk("sw_word", debug_data, 32'hDEADBEEF);

        // Byte store, signed and unsigned byte loads.
        cyc(1'b1, 9'h130, 32'h10, 32'h0, 1'b0, 8'd4);
        cyc(1'b1, 9'h100, 32'h13, 32'h00000080, 1'b0, 8'd4);
        cyc(1'b1, 9'h080, 32'h13, 32'h0, 1'b0, 8'd4);
        chk("sb_word", debug_data, 32'h80000000);
        cyc(1'b1, 9'h0C0, 32'h13, 32'h0, 1'b0, 8'd4);

        // Halfword store/load, then a misaligned halfword store.
        cyc(1'b1, 9'h110, 32'h22, 32'h00001234, 1'b0, 8'd8);
        cyc(1'b1, 9'h090, 32'h22, 32'h0, 1'b0, 8'd8);
        cyc(1'b1, 9'h110, 32'h21, 32'h0000BEEF, 1'b0, 8'd8);
        cyc(1'b1, 9'h0B2, 32'h23, 32'h0, 1'b0, 8'd8);

        // Branch resolution.
        cyc(1'b1, 9'h008, 32'h0, 32'h0, 1'b1, 8'd0);
        cyc(1'b1, 9'h004, 32'h0, 32'h0, 1'b1, 8'd0);
        cyc(1'b1, 9'h000, 32'h0, 32'h0, 1'b1, 8'd0);
        cyc(1'b1, 9'h004, 32'h0, 32'h0, 1'b0, 8'd0);

        // Address wrap past the top of memory.
        cyc(1'b1, 9'h130, 32'(DEPTH*4 + 8), 32'hCAFEF00D, 1'b0, 8'd2);
        cyc(1'b1, 9'h000, 32'h0, 32'h0, 1'b0, 8'd2);
        chk("wrap_word", debug_data, 32'hCAFEF00D);

        // Simultaneous store and load returns the old word; reserved size acts as word.
        cyc(1'b1, 9'h1A0, 32'h30, 32'h13572468, 1'b0, 8'd12);
        cyc(1'b1, 9'h0A0, 32'h30, 32'h0, 1'b0, 8'd12);

        // Randomized traffic over a small address window with high-bit garbage.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 31) != 0), 9'($urandom),
                32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 10) |
                (32'($urandom_range(0, 1)) << 31),
                $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (sb.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
